// File: rtl/apb_csr_master.sv
// apb_csr_master
//   APB requester for the ALU CSR slave. Each accepted command becomes one
//   SETUP->ACCESS transfer. Read data and the slave error flag come back on a
//   one-cycle response strobe. Saturating counters track completed and
//   errored transfers.
//
//   Optional feature: define APB_TIMEOUT_EN to add an ACCESS-phase watchdog.
//   The watchdog aborts a transfer after TIMEOUT_CYCLES cycles without ready.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FSM idle, comb)
//   cmd_write/addr/wdata        command direction, address, write data
//   rsp_valid                   one-cycle response strobe
//   rsp_rdata/err/timeout       response payload, held until next response
//   sel/en/write/addr/wdata     APB requester outputs (registered)
//   ready/rdata/slv_err         APB completer inputs
//   xfer_count/err_count        saturating transfer / error statistics
module apb_csr_master #(
   parameter int unsigned ADDR_WIDTH     = 3,
   parameter int unsigned APB_BUS_SIZE   = 32,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
   output logic                    rsp_valid,
   output logic [APB_BUS_SIZE-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    sel,
   output logic                    en,
   output logic                    write,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [APB_BUS_SIZE-1:0] wdata,
   input  logic                    ready,
   input  logic [APB_BUS_SIZE-1:0] rdata,
   input  logic                    slv_err,
   output logic [CNT_WIDTH-1:0]    xfer_count,
   output logic [CNT_WIDTH-1:0]    err_count
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t state, state_nxt;

   logic                    sel_nxt, en_nxt, write_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [APB_BUS_SIZE-1:0] wdata_nxt, rsp_rdata_nxt;
   logic                    rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
   logic [CNT_WIDTH-1:0]    xfer_count_nxt, err_count_nxt;
   logic                    timed_out;
   logic                    done;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt;

   // Held at zero outside ACCESS, so the count restarts on every entry.
   always_ff @(posedge clk) begin
      if (rst || state != ACCESS) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + 1'b1;
   end

   // Last permitted ACCESS cycle with no ready: abort instead of waiting.
   assign timed_out = (state == ACCESS) && !ready &&
                      (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   assign done      = (state == ACCESS) && (ready || timed_out);
   assign cmd_ready = (state == IDLE);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel         <= 1'b0;
         en          <= 1'b0;
         write       <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         xfer_count  <= '0;
         err_count   <= '0;
      end else begin
         state       <= state_nxt;
         sel         <= sel_nxt;
         en          <= en_nxt;
         write       <= write_nxt;
         addr        <= addr_nxt;
         wdata       <= wdata_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         rsp_timeout <= rsp_timeout_nxt;
         xfer_count  <= xfer_count_nxt;
         err_count   <= err_count_nxt;
      end
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      sel_nxt         = sel;
      en_nxt          = en;
      write_nxt       = write;
      addr_nxt        = addr;
      wdata_nxt       = wdata;
      rsp_valid_nxt   = 1'b0;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_err_nxt     = rsp_err;
      rsp_timeout_nxt = rsp_timeout;
      xfer_count_nxt  = xfer_count;
      err_count_nxt   = err_count;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               sel_nxt   = 1'b1;
               en_nxt    = 1'b0;
               write_nxt = cmd_write;
               addr_nxt  = cmd_addr;
               wdata_nxt = cmd_wdata;
            end
         end
         SETUP: en_nxt = 1'b1;
         ACCESS: begin
            if (done) begin
               sel_nxt         = 1'b0;
               en_nxt          = 1'b0;
               rsp_valid_nxt   = 1'b1;
               // A timeout has ready low, so slv_err is irrelevant there.
               rsp_err_nxt     = timed_out || slv_err;
               rsp_timeout_nxt = timed_out;
               rsp_rdata_nxt   = (ready && !write && !slv_err) ? rdata : '0;
               // Counters move together with the response strobe.
               if (xfer_count != '1)
                  xfer_count_nxt = xfer_count + 1'b1;
               if (rsp_err_nxt && err_count != '1)
                  err_count_nxt = err_count + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apb_csr_master.sv
module tb_apb_csr_master;

   localparam int TMO = 4;
   localparam int CMAX = 15;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        sel, en, write;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic        ready, slv_err;
   logic [31:0] rdata;
   logic [3:0]  xfer_count, err_count;

   int checks = 0;
   int errors = 0;
   int exp_x  = 0;
   int exp_e  = 0;

   apb_csr_master #(
      .ADDR_WIDTH(3), .APB_BUS_SIZE(32), .CNT_WIDTH(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .sel(sel), .en(en), .write(write), .addr(addr), .wdata(wdata),
      .ready(ready), .rdata(rdata), .slv_err(slv_err),
      .xfer_count(xfer_count), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference counter model: saturating statistics.
   task automatic model_rsp(input bit err);
      exp_x = (exp_x < CMAX) ? exp_x + 1 : CMAX;
      if (err) exp_e = (exp_e < CMAX) ? exp_e + 1 : CMAX;
   endtask

   // Issue one command from idle and act as the slave: ready is given on the
   // ACCESS cycle with index 'waits'. Reports what the DUT did.
   task automatic run_xfer(input bit w, input logic [2:0] a, input logic [31:0] d,
                           input int waits, input logic [31:0] rd, input bit se,
                           output int lat, output logic [31:0] r_rdata,
                           output bit r_err, output bit r_to, output bit stable,
                           output int sel_cyc, output int en_cyc);
      int acc;
      acc = 0; lat = -1; stable = cmd_ready; sel_cyc = 0; en_cyc = 0;
      r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 3'($urandom);
      cmd_wdata = $urandom;
      for (int c = 1; c <= 60; c++) begin
         ready = 1'b0; slv_err = 1'($urandom); rdata = $urandom;
         if (rsp_valid) begin
            lat = c; r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
            break;
         end
         if (sel) begin
            sel_cyc++;
            if (addr !== a || write !== w || wdata !== d) stable = 1'b0;
         end
         if (en) begin
            en_cyc++;
            if (!sel) stable = 1'b0;
            if (acc == waits) begin ready = 1'b1; rdata = rd; slv_err = se; end
            acc++;
         end
         @(negedge clk);
      end
      ready = 1'b0; slv_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; ready = 1'b0; slv_err = 1'b0; rdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({sel, en, write, rsp_valid, rsp_err, rsp_timeout} !== 6'b0 ||
          addr !== '0 || wdata !== '0 || rsp_rdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got sel=%b en=%b wr=%b rv=%b re=%b rt=%b addr=%0d wdata=%h rdata=%h, expected all zero",
                  sel, en, write, rsp_valid, rsp_err, rsp_timeout, addr, wdata, rsp_rdata);
      end
      checks++;
      if (xfer_count !== 4'd0 || err_count !== 4'd0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_counters: got xfer=%0d err=%0d cmd_ready=%b, expected 0 0 1",
                  xfer_count, err_count, cmd_ready);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write;
      int lat, sc, ec; logic [31:0] rr; bit re, rt, st;
      run_xfer(1'b1, 3'd1, 32'h5, 0, 32'hDEAD_BEEF, 1'b0, lat, rr, re, rt, st, sc, ec);
      model_rsp(1'b0);
      checks++;
      if (lat !== 3 || sc !== 2 || ec !== 1 || !st) begin
         errors++;
         $display("FAIL write_timing: got lat=%0d sel=%0d en=%0d stable=%0b, expected 3 2 1 1",
                  lat, sc, ec, st);
      end
      checks++;
      if (re !== 1'b0 || rr !== 32'h0 || rt !== 1'b0 || xfer_count !== 4'(exp_x)) begin
         errors++;
         $display("FAIL write_rsp: got err=%b rdata=%h to=%b xfer=%0d, expected 0 0 0 %0d",
                  re, rr, rt, xfer_count, exp_x);
      end
   endtask

   task automatic test_read_wait;
      int lat, sc, ec; logic [31:0] rr; bit re, rt, st;
      run_xfer(1'b0, 3'd3, 32'h0, 1, 32'h0000_ABCD, 1'b0, lat, rr, re, rt, st, sc, ec);
      model_rsp(1'b0);
      checks++;
      if (lat !== 4 || sc !== 3 || ec !== 2 || !st) begin
         errors++;
         $display("FAIL read_wait_timing: got lat=%0d sel=%0d en=%0d stable=%0b, expected 4 3 2 1",
                  lat, sc, ec, st);
      end
      checks++;
      if (rr !== 32'h0000_ABCD || re !== 1'b0) begin
         errors++;
         $display("FAIL read_wait_data: got rdata=%h err=%b, expected 0000abcd 0", rr, re);
      end
   endtask

   task automatic test_slv_err;
      int lat, sc, ec; logic [31:0] rr; bit re, rt, st;
      run_xfer(1'b1, 3'd3, 32'h1234, 0, 32'hFFFF_FFFF, 1'b1, lat, rr, re, rt, st, sc, ec);
      model_rsp(1'b1);
      checks++;
      if (re !== 1'b1 || rr !== 32'h0 || rt !== 1'b0 || lat !== 3) begin
         errors++;
         $display("FAIL slv_err_rsp: got err=%b rdata=%h to=%b lat=%0d, expected 1 0 0 3",
                  re, rr, rt, lat);
      end
      checks++;
      if (err_count !== 4'(exp_e) || xfer_count !== 4'(exp_x)) begin
         errors++;
         $display("FAIL slv_err_counts: got xfer=%0d err=%0d, expected %0d %0d",
                  xfer_count, err_count, exp_x, exp_e);
      end
   endtask

   task automatic test_back_to_back;
      int rsp_t[$];
      logic [31:0] exp_rd[$];
      bit s[0:20];
      int idx, lows;
      bit acc, rd_ok;
      logic [31:0] want;
      idx = 0; rd_ok = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_wdata = '0;
      for (int c = 0; c <= 20; c++) begin
         s[c] = sel;
         if (rsp_valid) begin
            rsp_t.push_back(c);
            want = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hx;
            if (rsp_rdata !== want) rd_ok = 1'b0;
            model_rsp(1'b0);
         end
         acc = cmd_valid && cmd_ready;
         ready = en; slv_err = 1'b0; rdata = $urandom;
         if (en) exp_rd.push_back(rdata);
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx == 3) cmd_valid = 1'b0;
            else cmd_addr = 3'(idx);
         end
      end
      ready = 1'b0;
      lows = 0;
      for (int c = 1; c <= 8; c++) if (!s[c]) lows++;
      checks++;
      if (rsp_t.size() != 3 || rsp_t[0] != 3 || rsp_t[1] != 6 || rsp_t[2] != 9) begin
         errors++;
         $display("FAIL b2b_rsp_spacing: got %0d rsps first=%0d, expected 3 rsps at cycles 3,6,9",
                  rsp_t.size(), (rsp_t.size() > 0) ? rsp_t[0] : -1);
      end
      checks++;
      if (lows != 2 || !s[1] || !s[2] || s[3] || !s[4]) begin
         errors++;
         $display("FAIL b2b_sel_gap: got %0d sel-low cycles in 1..8, expected 2 single gaps", lows);
      end
      checks++;
      if (!rd_ok || xfer_count !== 4'(exp_x)) begin
         errors++;
         $display("FAIL b2b_data_count: got rdata_ok=%0b xfer=%0d, expected 1 %0d",
                  rd_ok, xfer_count, exp_x);
      end
   endtask

   task automatic test_random;
      int lat, sc, ec, waits, bad;
      logic [31:0] rr, d, rd, want;
      bit re, rt, st, w, se;
      logic [2:0] a;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         w = 1'($urandom); a = 3'($urandom_range(4)); d = $urandom; rd = $urandom;
         se = ($urandom_range(3) == 0); waits = $urandom_range(TMO - 1);
         run_xfer(w, a, d, waits, rd, se, lat, rr, re, rt, st, sc, ec);
         model_rsp(se);
         want = (!w && !se) ? rd : 32'h0;
         checks++;
         if (lat !== 3 + waits || rr !== want || re !== se || rt !== 1'b0 || !st ||
             sc !== 2 + waits || ec !== 1 + waits) begin
            errors++; bad++;
            $display("FAIL random_xfer%0d: got lat=%0d rdata=%h err=%b to=%b stable=%0b, expected lat=%0d rdata=%h err=%b to=0 stable=1",
                     n, lat, rr, re, rt, st, 3 + waits, want, se);
         end
      end
      checks++;
      if (xfer_count !== 4'(exp_x) || err_count !== 4'(exp_e)) begin
         errors++;
         $display("FAIL random_counts_sat: got xfer=%0d err=%0d, expected %0d %0d",
                  xfer_count, err_count, exp_x, exp_e);
      end
   endtask

   task automatic test_stuck;
`ifdef APB_TIMEOUT_EN
      int lat, sc, ec; logic [31:0] rr; bit re, rt, st;
      run_xfer(1'b0, 3'd2, 32'h0, 1000, 32'h1111_2222, 1'b0, lat, rr, re, rt, st, sc, ec);
      model_rsp(1'b1);
      checks++;
      if (lat !== 2 + TMO || ec !== TMO || re !== 1'b1 || rt !== 1'b1 || rr !== 32'h0) begin
         errors++;
         $display("FAIL timeout_abort: got lat=%0d en=%0d err=%b to=%b rdata=%h, expected %0d %0d 1 1 0",
                   lat, ec, re, rt, rr, 2 + TMO, TMO);
      end
      checks++;
      if (err_count !== 4'(exp_e) || xfer_count !== 4'(exp_x)) begin
         errors++;
         $display("FAIL timeout_counts: got xfer=%0d err=%0d, expected %0d %0d",
                  xfer_count, err_count, exp_x, exp_e);
      end
`else
      int held, rsps, lat;
      held = 0; rsps = 0; lat = -1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         ready = 1'b0; slv_err = 1'($urandom); rdata = $urandom;
         if (sel && en) held++;
         if (rsp_valid) rsps++;
         @(negedge clk);
      end
      checks++;
      if (held != 29 || rsps != 0 || rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL stuck_hold: got access cycles=%0d rsps=%0d to=%b, expected 29 0 0",
                  held, rsps, rsp_timeout);
      end
      ready = 1'b1; slv_err = 1'b0; rdata = 32'h0BAD_F00D;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         ready = 1'b0;
         if (rsp_valid) begin lat = c; break; end
      end
      model_rsp(1'b0);
      checks++;
      if (lat != 1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL stuck_release: got lat=%0d rdata=%h err=%b, expected 1 0badf00d 0",
                  lat, rsp_rdata, rsp_err);
      end
      @(negedge clk);
`endif
   endtask

   task automatic test_reset_mid;
      int seen, rsps, sels;
      seen = 0; rsps = 0; sels = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_wdata = 32'hCAFE;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 10 && seen < 2; c++) begin
         ready = 1'b0;
         if (en) seen++;
         if (seen < 2) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_x = 0; exp_e = 0;
      checks++;
      if (seen != 2 || sel !== 1'b0 || en !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
          xfer_count !== 4'd0 || err_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_access: got seen=%0d sel=%b en=%b rv=%b rdy=%b xfer=%0d err=%0d, expected 2 0 0 0 1 0 0",
                  seen, sel, en, rsp_valid, cmd_ready, xfer_count, err_count);
      end
      for (int c = 0; c < 5; c++) begin
         ready = 1'b1;
         @(negedge clk);
         if (rsp_valid) rsps++;
         if (sel) sels++;
      end
      ready = 1'b0;
      checks++;
      if (rsps != 0 || sels != 0) begin
         errors++;
         $display("FAIL reset_mid_dropped: got rsps=%0d sel cycles=%0d, expected 0 0", rsps, sels);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slv_err();
      test_back_to_back();
      test_random();
      test_stuck();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

endmodule
